io_input_debounce: RTL and testbench

Conditioning stage directly upstream of the memory-mapped input-port register bank. It takes three raw, asynchronous PORT_W-bit board inputs (switches and buttons). Each bit is passed through a 2-flop synchronizer, then a per-bit stability counter. The resulting clean values drive the in_port0/1/2 inputs of the input register bank, and a one-cycle pulse flags any change in the debounced values.

---
 rtl/io_input_debounce.sv | 102 ++++++++++
 tb/tb_io_input_debounce.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_debounce.sv
// Input-port conditioning: 2-flop synchronizer and per-bit stability counter on
// every lane of three raw board ports. Optional sticky press flags under IO_EDGE_LATCH_EN.
module io_input_debounce #(
    parameter int PORT_W    = 4,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic                  io_clk,
    input  logic                  reset,
    input  logic [PORT_W-1:0]     raw_port0,
    input  logic [PORT_W-1:0]     raw_port1,
    input  logic [PORT_W-1:0]     raw_port2,
    output logic [PORT_W-1:0]     in_port0,
    output logic [PORT_W-1:0]     in_port1,
    output logic [PORT_W-1:0]     in_port2,
    output logic                  change_pulse,
    input  logic                  press_clr,
    output logic [3*PORT_W-1:0]   press_latch
);

    localparam int LANES = 3 * PORT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [LANES-1:0]            raw_s;
    logic [LANES-1:0]            s1_q;
    logic [LANES-1:0]            s2_q;
    logic [LANES-1:0]            stable_q;
    logic [LANES-1:0]            stable_d;
    logic [LANES-1:0][CNT_W-1:0] cnt_q;
    logic [LANES-1:0][CNT_W-1:0] cnt_d;
    logic                        change_q;
    logic                        change_d;

    assign raw_s = {raw_port2, raw_port1, raw_port0};

    // A lane only adopts its synchronized value after DB_CYCLES consecutive mismatching edges.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < LANES; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = {CNT_W{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        change_d = |(stable_d ^ stable_q);
    end

    // Synchronizer, counter and debounced-value registers.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            s1_q     <= {LANES{1'b0}};
            s2_q     <= {LANES{1'b0}};
            stable_q <= {LANES{1'b0}};
            cnt_q    <= {(LANES*CNT_W){1'b0}};
            change_q <= 1'b0;
        end else begin
            s1_q     <= raw_s;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
        end
    end

    assign in_port0     = stable_q[PORT_W-1:0];
    assign in_port1     = stable_q[2*PORT_W-1:PORT_W];
    assign in_port2     = stable_q[3*PORT_W-1:2*PORT_W];
    assign change_pulse = change_q;

`ifdef IO_EDGE_LATCH_EN
    logic [LANES-1:0] latch_q;
    logic [LANES-1:0] latch_d;

    // A new rising edge outranks a clear arriving on the same edge.
    always_comb begin
        latch_d = (latch_q & ~{LANES{press_clr}}) | (stable_d & ~stable_q);
    end

    // Sticky press flags.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            latch_q <= {LANES{1'b0}};
        end else begin
            latch_q <= latch_d;
        end
    end

    assign press_latch = latch_q;
`else
    logic unused_press_clr_s;

    assign unused_press_clr_s = press_clr;
    assign press_latch        = {LANES{1'b0}};
`endif

endmodule

// File: tb/tb_io_input_debounce.sv
// Bench for io_input_debounce: directed scenarios plus random traffic, all compared
// against a sliding-window reference model of the debounce rule.
module tb_io_input_debounce;

    localparam int PORT_W = 4;
    localparam int DB     = 4;
    localparam int CNT_W  = 3;
    localparam int LANES  = 3 * PORT_W;
    localparam int MAXT   = 8192;
`ifdef IO_EDGE_LATCH_EN
    localparam bit LATCH_EN = 1'b1;
`else
    localparam bit LATCH_EN = 1'b0;
`endif

    logic              io_clk;
    logic              reset;
    logic [PORT_W-1:0] raw_port0, raw_port1, raw_port2;
    logic [PORT_W-1:0] in_port0, in_port1, in_port2;
    logic              change_pulse;
    logic              press_clr;
    logic [LANES-1:0]  press_latch;

    io_input_debounce #(.PORT_W(PORT_W), .DB_CYCLES(DB), .CNT_W(CNT_W)) dut (
        .io_clk      (io_clk),
        .reset       (reset),
        .raw_port0   (raw_port0),
        .raw_port1   (raw_port1),
        .raw_port2   (raw_port2),
        .in_port0    (in_port0),
        .in_port1    (in_port1),
        .in_port2    (in_port2),
        .change_pulse(change_pulse),
        .press_clr   (press_clr),
        .press_latch (press_latch)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: per-edge logs of inputs and the model's outputs.
    logic [LANES-1:0] raw_log [0:MAXT-1];
    logic             rst_log [0:MAXT-1];
    int               t        = 0;
    int               last_rst = -1000;
    logic [LANES-1:0] m_stable = '0;
    logic             m_pulse  = 1'b0;
    logic [LANES-1:0] m_latch  = '0;

    // Value the lane compares against at edge j: raw sampled two edges earlier,
    // or zero if a reset fell on either of the two preceding edges.
    function automatic logic [LANES-1:0] seen(input int j);
        if (j < 2) return '0;
        if (rst_log[j-1] || rst_log[j-2]) return '0;
        return raw_log[j-2];
    endfunction

    task automatic tick();
        logic [LANES-1:0] nxt;
        logic [LANES-1:0] sv;
        logic             upd;
        @(posedge io_clk);
        if (t < MAXT) begin
            raw_log[t] = {raw_port2, raw_port1, raw_port0};
            rst_log[t] = reset;
            if (reset) begin
                m_stable = '0;
                m_pulse  = 1'b0;
                m_latch  = '0;
                last_rst = t;
            end else begin
                nxt = m_stable;
                for (int b = 0; b < LANES; b++) begin
                    upd = 1'b1;
                    for (int j = t - DB + 1; j <= t; j++) begin
                        if (j <= last_rst) begin
                            upd = 1'b0;
                        end else begin
                            sv = seen(j);
                            if (sv[b] == m_stable[b]) upd = 1'b0;
                        end
                    end
                    if (upd) nxt[b] = ~m_stable[b];
                end
                m_pulse = (nxt != m_stable);
                if (LATCH_EN) m_latch = (m_latch & ~{LANES{press_clr}}) | (nxt & ~m_stable);
                else          m_latch = '0;
                m_stable = nxt;
            end
        end
        t++;
        #1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; raw_port0 = 4'hF; raw_port1 = 4'h0; raw_port2 = 4'h0; press_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (in_port0 !== 4'h0 || change_pulse !== 1'b0 || press_latch !== 12'h000) begin
                errors++;
                $display("FAIL reset_state k=%0d got in0=%h pulse=%b latch=%h exp 0 0 000", k, in_port0, change_pulse, press_latch);
            end
        end
        reset = 1'b0; raw_port0 = 4'h0;
        for (int k = 0; k < DB + 3; k++) begin
            tick();
            checks++;
            if ({in_port2, in_port1, in_port0} !== m_stable || change_pulse !== m_pulse || press_latch !== m_latch) begin
                errors++;
                $display("FAIL reset_model t=%0d got %h/%b/%h exp %h/%b/%h", t, {in_port2, in_port1, in_port0}, change_pulse, press_latch, m_stable, m_pulse, m_latch);
            end
        end
    endtask

    task automatic test_latency();
        raw_port0 = 4'h5;
        for (int k = 1; k <= DB + 3; k++) begin
            tick();
            checks++;
            if (k < DB + 2 && (in_port0 !== 4'h0 || change_pulse !== 1'b0)) begin
                errors++;
                $display("FAIL latency_early k=%0d got in0=%h pulse=%b exp 0 0", k, in_port0, change_pulse);
            end else if (k == DB + 2 && (in_port0 !== 4'h5 || change_pulse !== 1'b1)) begin
                errors++;
                $display("FAIL latency_update k=%0d got in0=%h pulse=%b exp 5 1", k, in_port0, change_pulse);
            end else if (k == DB + 3 && (in_port0 !== 4'h5 || change_pulse !== 1'b0)) begin
                errors++;
                $display("FAIL latency_after k=%0d got in0=%h pulse=%b exp 5 0", k, in_port0, change_pulse);
            end
        end
        raw_port0 = 4'h0;
        settle(DB + 4);
        checks++;
        if (in_port0 !== 4'h0 || m_stable !== 12'h000) begin
            errors++;
            $display("FAIL latency_return got in0=%h exp 0", in_port0);
        end
    endtask

    task automatic test_glitch();
        raw_port1 = 4'h4;
        for (int k = 0; k < 3 + 10; k++) begin
            tick();
            if (k == 2) raw_port1 = 4'h0;
            checks++;
            if (in_port1 !== 4'h0 || change_pulse !== 1'b0 || m_pulse !== 1'b0) begin
                errors++;
                $display("FAIL glitch k=%0d got in1=%h pulse=%b exp 0 0", k, in_port1, change_pulse);
            end
        end
    endtask

    task automatic test_simultaneous();
        raw_port2 = 4'hA; raw_port0 = 4'h3;
        for (int k = 1; k <= DB + 3; k++) begin
            tick();
            checks++;
            if (k <= DB + 1 && ({in_port2, in_port0} !== 8'h00 || change_pulse !== 1'b0)) begin
                errors++;
                $display("FAIL simul_early k=%0d got in2=%h in0=%h pulse=%b exp 0 0 0", k, in_port2, in_port0, change_pulse);
            end else if (k == DB + 2 && ({in_port2, in_port0} !== 8'hA3 || change_pulse !== 1'b1)) begin
                errors++;
                $display("FAIL simul_update k=%0d got in2=%h in0=%h pulse=%b exp A 3 1", k, in_port2, in_port0, change_pulse);
            end else if (k == DB + 3 && ({in_port2, in_port0} !== 8'hA3 || change_pulse !== 1'b0)) begin
                errors++;
                $display("FAIL simul_single k=%0d got pulse=%b exp 0", k, change_pulse);
            end
        end
        raw_port2 = 4'h0; raw_port0 = 4'h0;
        settle(DB + 4);
    endtask

    task automatic test_reset_midcount();
        raw_port0 = 4'h1;
        settle(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= DB + 2; k++) begin
            tick();
            checks++;
            if ((k < DB + 2 && in_port0 !== 4'h0) || (k == DB + 2 && in_port0 !== 4'h1)) begin
                errors++;
                $display("FAIL midcount_reset k=%0d got in0=%h exp %h", k, in_port0, (k == DB + 2) ? 4'h1 : 4'h0);
            end
            checks++;
            if ({in_port2, in_port1, in_port0} !== m_stable || change_pulse !== m_pulse) begin
                errors++;
                $display("FAIL midcount_model k=%0d got %h/%b exp %h/%b", k, {in_port2, in_port1, in_port0}, change_pulse, m_stable, m_pulse);
            end
        end
    endtask

    task automatic test_latch();
        reset = 1'b1; raw_port0 = 4'h0;
        tick();
        reset = 1'b0;
        raw_port0 = 4'h1;
        settle(DB + 2);
        checks++;
        if (press_latch[0] !== LATCH_EN || in_port0 !== 4'h1) begin
            errors++;
            $display("FAIL latch_set got latch0=%b in0=%h exp %b 1", press_latch[0], in_port0, LATCH_EN);
        end
        raw_port0 = 4'h0;
        settle(DB + 2);
        checks++;
        if (press_latch[0] !== LATCH_EN || in_port0 !== 4'h0) begin
            errors++;
            $display("FAIL latch_sticky got latch0=%b in0=%h exp %b 0", press_latch[0], in_port0, LATCH_EN);
        end
        raw_port0 = 4'h2;
        settle(DB + 1);
        press_clr = 1'b1;
        tick();
        press_clr = 1'b0;
        checks++;
        if (press_latch[1:0] !== {LATCH_EN, 1'b0} || in_port0 !== 4'h2 || press_latch !== m_latch) begin
            errors++;
            $display("FAIL latch_clr_vs_set got latch=%h in0=%h exp latch[1:0]=%b%b in0=2", press_latch, in_port0, LATCH_EN, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) raw_port0 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) raw_port1 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) raw_port2 = 4'($urandom);
            press_clr = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if ({in_port2, in_port1, in_port0} !== m_stable || change_pulse !== m_pulse || press_latch !== m_latch) begin
                errors++;
                $display("FAIL random t=%0d got %h/%b/%h exp %h/%b/%h", t, {in_port2, in_port1, in_port0}, change_pulse, press_latch, m_stable, m_pulse, m_latch);
            end
        end
        reset = 1'b0; press_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; raw_port0 = '0; raw_port1 = '0; raw_port2 = '0; press_clr = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
        test_latch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
